machine_timer: RTL and testbench

MACHINE_TIMER -- requirements
Module: machine_timer

---
 rtl/machine_timer.sv | 165 ++++++++++++++++
 tb/tb_machine_timer.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/machine_timer.sv
// Machine timer peripheral (mtime / mtimecmp / msip) behind a simple
// request/response register bus.
//
// A 16-bit prescaler divides clk by CLOCK_DIVIDER and advances the 64-bit
// mtime counter. The timer interrupt is a registered compare of mtime
// against mtimecmp. The software interrupt is the MSIP register bit.
//
// Ports
//   clk                           : single clock, rising edge
//   reset                         : asynchronous, active-low reset
//   read_request / write_request  : bus requests, sampled while idle
//   address[15:0]                 : register byte offset (no base decode)
//   write_data[31:0]              : write payload
//   read_data[31:0]               : read payload, valid while response=1
//   response                      : one-cycle completion pulse
//   instruction_request_timer     : mip.MTIP level
//   instruction_request_software  : mip.MSIP level
//   mtime_value[63:0]             : current mtime for the TIME/TIMEH CSRs
module machine_timer #(
  parameter int unsigned CLOCK_DIVIDER = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        read_request,
  input  logic        write_request,
  input  logic [15:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        response,
  output logic        instruction_request_timer,
  output logic        instruction_request_software,
  output logic [63:0] mtime_value
);

  localparam logic [15:0] ADDR_MSIP     = 16'h0000;
  localparam logic [15:0] ADDR_MTCMP_LO = 16'h4000;
  localparam logic [15:0] ADDR_MTCMP_HI = 16'h4004;
  localparam logic [15:0] ADDR_MTIME_LO = 16'hBFF8;
  localparam logic [15:0] ADDR_MTIME_HI = 16'hBFFC;
  localparam logic [15:0] PRESC_LAST    = 16'(CLOCK_DIVIDER - 1);

  typedef enum logic {
    IDLE    = 1'b0,
    RESPOND = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic        accept;
  logic        wr_en, rd_en;
  logic        wr_msip, wr_cmp_lo, wr_cmp_hi, wr_mtime_lo, wr_mtime_hi;
  logic        tick;
  logic [15:0] presc_q, presc_d;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        msip_q, msip_d;
  logic        mtip_q, mtip_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] reg_rdata;

  // Bus FSM: a request is accepted only from IDLE; RESPOND lasts exactly
  // one cycle and ignores whatever the master is still driving.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (read_request || write_request) begin
          state_d = RESPOND;
          accept  = 1'b1;
        end
      end
      RESPOND: state_d = IDLE;
    endcase
  end

  // A simultaneous read+write is treated as a write, so the read path stays 0.
  assign wr_en = accept & write_request;
  assign rd_en = accept & read_request & ~write_request;

  assign wr_msip     = wr_en && (address == ADDR_MSIP);
  assign wr_cmp_lo   = wr_en && (address == ADDR_MTCMP_LO);
  assign wr_cmp_hi   = wr_en && (address == ADDR_MTCMP_HI);
  assign wr_mtime_lo = wr_en && (address == ADDR_MTIME_LO);
  assign wr_mtime_hi = wr_en && (address == ADDR_MTIME_HI);

  assign tick = (presc_q == PRESC_LAST);

  // Writing either mtime half restarts the prescaler so a full divider
  // period elapses before the next increment.
  always_comb begin
    presc_d = presc_q + 16'd1;
    if (tick || wr_mtime_lo || wr_mtime_hi) begin
      presc_d = '0;
    end
  end

  // A written half wins over a coincident increment, and the untouched half
  // keeps its old value: no carry is propagated on a write cycle.
  always_comb begin
    mtime_d = mtime_q;
    if (wr_mtime_lo) begin
      mtime_d = {mtime_q[63:32], write_data};
    end else if (wr_mtime_hi) begin
      mtime_d = {write_data, mtime_q[31:0]};
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end
  end

  always_comb begin
    mtimecmp_d = mtimecmp_q;
    if (wr_cmp_lo) begin
      mtimecmp_d = {mtimecmp_q[63:32], write_data};
    end else if (wr_cmp_hi) begin
      mtimecmp_d = {write_data, mtimecmp_q[31:0]};
    end
  end

  assign msip_d = wr_msip ? write_data[0] : msip_q;

  // Compare uses the current register values, so the interrupt lags any
  // change of mtime or mtimecmp by one cycle.
  assign mtip_d = (mtime_q >= mtimecmp_q);

  always_comb begin
    case (address)
      ADDR_MSIP:     reg_rdata = {31'd0, msip_q};
      ADDR_MTCMP_LO: reg_rdata = mtimecmp_q[31:0];
      ADDR_MTCMP_HI: reg_rdata = mtimecmp_q[63:32];
      ADDR_MTIME_LO: reg_rdata = mtime_q[31:0];
      ADDR_MTIME_HI: reg_rdata = mtime_q[63:32];
      default:       reg_rdata = 32'd0;
    endcase
  end

  // read_data is captured at the accept edge and is zero in every other cycle.
  assign rdata_d = rd_en ? reg_rdata : 32'd0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      presc_q    <= '0;
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      msip_q     <= 1'b0;
      mtip_q     <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
      mtip_q     <= mtip_d;
      rdata_q    <= rdata_d;
    end
  end

  assign response                     = (state_q == RESPOND);
  assign read_data                    = rdata_q;
  assign instruction_request_timer    = mtip_q;
  assign instruction_request_software = msip_q;
  assign mtime_value                  = mtime_q;

endmodule

// File: tb/tb_machine_timer.sv
// Testbench for machine_timer: one instance with CLOCK_DIVIDER=1 for the bus
// and interrupt scenarios, a second with CLOCK_DIVIDER=4 for prescaling.
// The mtime reference is an anchor value plus elapsed edges divided by the
// divider; it is re-anchored whenever the bench writes an mtime half.
module tb_machine_timer;

  localparam logic [15:0] A_MSIP = 16'h0000;
  localparam logic [15:0] A_CMPL = 16'h4000;
  localparam logic [15:0] A_CMPH = 16'h4004;
  localparam logic [15:0] A_MTL  = 16'hBFF8;
  localparam logic [15:0] A_MTH  = 16'hBFFC;

  logic        clk = 1'b0;
  logic        reset;
  logic        read_request, write_request;
  logic [15:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        response, irq_t, irq_s;
  logic [63:0] mtime_value;

  logic        reset4, rr4, wr4;
  logic [15:0] a4;
  logic [31:0] d4;
  logic [31:0] rd4;
  logic        resp4, it4, is4;
  logic [63:0] mt4;

  int     total  = 0;
  int     passed = 0;
  longint cyc    = 0;

  // reference model state
  logic [63:0] anc_val;
  longint      anc_e;
  logic [63:0] cmp_m;
  logic        msip_m;

  machine_timer #(.CLOCK_DIVIDER(1)) dut (
    .clk(clk), .reset(reset), .read_request(read_request),
    .write_request(write_request), .address(address), .write_data(write_data),
    .read_data(read_data), .response(response),
    .instruction_request_timer(irq_t), .instruction_request_software(irq_s),
    .mtime_value(mtime_value)
  );

  machine_timer #(.CLOCK_DIVIDER(4)) dut4 (
    .clk(clk), .reset(reset4), .read_request(rr4),
    .write_request(wr4), .address(a4), .write_data(d4),
    .read_data(rd4), .response(resp4),
    .instruction_request_timer(it4), .instruction_request_software(is4),
    .mtime_value(mt4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

  // mtime value holding after edge number e
  function automatic logic [63:0] mt_at(input longint e);
    return anc_val + 64'(e - anc_e);
  endfunction

  // register contents as seen by a read accepted at edge e+1
  function automatic logic [31:0] reg_at(input logic [15:0] a, input longint e);
    logic [63:0] m;
    m = mt_at(e);
    case (a)
      A_MSIP:  return {31'd0, msip_m};
      A_CMPL:  return cmp_m[31:0];
      A_CMPH:  return cmp_m[63:32];
      A_MTL:   return m[31:0];
      A_MTH:   return m[63:32];
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset_release();
    anc_val = 64'd0;
    anc_e   = cyc;
    cmp_m   = '1;
    msip_m  = 1'b0;
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    read_request = 1'b0;
    write_request = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset_release();
  endtask

  // One bus transaction; returns the accept edge and what was observed in
  // the response cycle and the cycle after it. Updates the model on writes.
  task automatic bus(input logic rd, input logic wr, input logic [15:0] a,
                     input logic [31:0] d, output longint c,
                     output logic r_at, output logic [31:0] rd_at,
                     output logic r_after, output logic [31:0] rd_after);
    logic [63:0] pre;
    read_request  = rd;
    write_request = wr;
    address       = a;
    write_data    = d;
    @(posedge clk); #1;
    c     = cyc;
    r_at  = response;
    rd_at = read_data;
    read_request  = 1'b0;
    write_request = 1'b0;
    if (wr) begin
      pre = mt_at(c - 1);
      case (a)
        A_MSIP: msip_m = d[0];
        A_CMPL: cmp_m[31:0] = d;
        A_CMPH: cmp_m[63:32] = d;
        A_MTL:  begin anc_val = {pre[63:32], d}; anc_e = c; end
        A_MTH:  begin anc_val = {d, pre[31:0]}; anc_e = c; end
        default: ;
      endcase
    end
    @(posedge clk); #1;
    r_after  = response;
    rd_after = read_data;
  endtask

  task automatic test_reset();
    #1;
    reset  = 1'b0;
    reset4 = 1'b0;
    #2;
    total++; if (mtime_value !== 64'd0) $display("FAIL rst_mtime got %h exp 0", mtime_value); else passed++;
    total++; if (response !== 1'b0) $display("FAIL rst_resp got %b exp 0", response); else passed++;
    total++; if (read_data !== 32'd0) $display("FAIL rst_rdata got %h exp 0", read_data); else passed++;
    total++; if (irq_t !== 1'b0 || irq_s !== 1'b0) $display("FAIL rst_irq got %b%b exp 00", irq_t, irq_s); else passed++;
    @(posedge clk);
    @(posedge clk); #1;
    reset  = 1'b1;
    reset4 = 1'b1;
    model_reset_release();
    @(posedge clk); #1;
    total++; if (mtime_value !== 64'd1) $display("FAIL rst_first_inc got %h exp 1", mtime_value); else passed++;
    repeat (5) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    total++; if (mtime_value !== 64'd0) $display("FAIL rst_async_mtime got %h exp 0", mtime_value); else passed++;
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset_release();
  endtask

  task automatic test_timer_irq();
    longint c;
    logic r0, r1;
    logic [31:0] d0, d1;
    logic exp;
    apply_reset();
    bus(1'b0, 1'b1, A_CMPL, 32'd10, c, r0, d0, r1, d1);
    bus(1'b0, 1'b1, A_CMPH, 32'd0, c, r0, d0, r1, d1);
    for (int i = 0; i < 14; i++) begin
      exp = (mt_at(cyc - 1) >= cmp_m);
      total++; if (irq_t !== exp) $display("FAIL timer_irq cyc=%0d got %b exp %b", cyc, irq_t, exp); else passed++;
      @(posedge clk); #1;
    end
    total++; if (irq_t !== 1'b1) $display("FAIL timer_irq_final got %b exp 1", irq_t); else passed++;
  endtask

  task automatic test_msip();
    longint c;
    logic r0, r1;
    logic [31:0] d0, d1;
    bus(1'b0, 1'b1, A_MSIP, 32'h1, c, r0, d0, r1, d1);
    total++; if (r0 !== 1'b1 || r1 !== 1'b0) $display("FAIL msip_resp got %b%b exp 10", r0, r1); else passed++;
    total++; if (irq_s !== 1'b1) $display("FAIL msip_set got %b exp 1", irq_s); else passed++;
    bus(1'b0, 1'b1, A_MSIP, 32'h0, c, r0, d0, r1, d1);
    total++; if (irq_s !== 1'b0) $display("FAIL msip_clr got %b exp 0", irq_s); else passed++;
    bus(1'b0, 1'b1, A_MSIP, 32'hFFFF_FFFF, c, r0, d0, r1, d1);
    bus(1'b1, 1'b0, A_MSIP, 32'h0, c, r0, d0, r1, d1);
    total++; if (d0 !== 32'h1 || r0 !== 1'b1) $display("FAIL msip_read got %h/%b exp 00000001/1", d0, r0); else passed++;
    total++; if (d1 !== 32'h0 || r1 !== 1'b0) $display("FAIL msip_read_after got %h/%b exp 0/0", d1, r1); else passed++;
  endtask

  task automatic test_wrap();
    longint c;
    logic r0, r1;
    logic [31:0] d0, d1;
    logic [31:0] exp;
    bus(1'b0, 1'b1, A_MTH, 32'h0, c, r0, d0, r1, d1);
    bus(1'b0, 1'b1, A_MTL, 32'hFFFF_FFFF, c, r0, d0, r1, d1);
    total++; if (mtime_value !== 64'h0000_0001_0000_0000) $display("FAIL carry got %h exp 0000000100000000", mtime_value); else passed++;
    bus(1'b1, 1'b0, A_MTH, 32'h0, c, r0, d0, r1, d1);
    total++; if (d0 !== 32'h1) $display("FAIL carry_read_hi got %h exp 00000001", d0); else passed++;
    bus(1'b1, 1'b0, A_MTL, 32'h0, c, r0, d0, r1, d1);
    exp = reg_at(A_MTL, c - 1);
    total++; if (d0 !== exp) $display("FAIL carry_read_lo got %h exp %h", d0, exp); else passed++;
    bus(1'b0, 1'b1, A_MTH, 32'hFFFF_FFFF, c, r0, d0, r1, d1);
    bus(1'b0, 1'b1, A_MTL, 32'hFFFF_FFFF, c, r0, d0, r1, d1);
    total++; if (mtime_value !== 64'd0) $display("FAIL wrap64 got %h exp 0", mtime_value); else passed++;
  endtask

  task automatic test_simul_rw();
    longint c;
    logic r0, r1;
    logic [31:0] d0, d1, v, exp;
    v = $urandom | 32'h1;
    bus(1'b1, 1'b1, A_CMPL, v, c, r0, d0, r1, d1);
    total++; if (r0 !== 1'b1 || r1 !== 1'b0) $display("FAIL rw_pulse got %b%b exp 10", r0, r1); else passed++;
    total++; if (d0 !== 32'd0) $display("FAIL rw_rdata got %h exp 0", d0); else passed++;
    bus(1'b1, 1'b0, A_CMPL, 32'h0, c, r0, d0, r1, d1);
    total++; if (d0 !== v) $display("FAIL rw_applied got %h exp %h", d0, v); else passed++;
    bus(1'b0, 1'b1, 16'h1234, 32'hDEAD_BEEF, c, r0, d0, r1, d1);
    total++; if (r0 !== 1'b1) $display("FAIL unmapped_wr_resp got %b exp 1", r0); else passed++;
    bus(1'b1, 1'b0, 16'h1234, 32'h0, c, r0, d0, r1, d1);
    total++; if (d0 !== 32'd0 || r0 !== 1'b1) $display("FAIL unmapped_rd got %h/%b exp 0/1", d0, r0); else passed++;
    bus(1'b1, 1'b0, A_CMPL, 32'h0, c, r0, d0, r1, d1);
    exp = cmp_m[31:0];
    total++; if (d0 !== exp) $display("FAIL unmapped_no_effect got %h exp %h", d0, exp); else passed++;
  endtask

  task automatic test_hold();
    longint c;
    logic r0, r1;
    logic [31:0] d0, d1, v;
    v = $urandom;
    write_request = 1'b1;
    address       = A_CMPH;
    write_data    = v;
    @(posedge clk); #1;
    total++; if (response !== 1'b1) $display("FAIL hold_resp got %b exp 1", response); else passed++;
    cmp_m[63:32] = v;
    write_data = ~v;
    @(posedge clk); #1;
    total++; if (response !== 1'b0) $display("FAIL hold_ignored_resp got %b exp 0", response); else passed++;
    write_request = 1'b0;
    bus(1'b1, 1'b0, A_CMPH, 32'h0, c, r0, d0, r1, d1);
    total++; if (d0 !== v) $display("FAIL hold_ignored_data got %h exp %h", d0, v); else passed++;
  endtask

  task automatic test_div4();
    longint k, c;
    logic [63:0] exp;
    @(posedge clk); #1;
    reset4 = 1'b0;
    @(posedge clk); #1;
    reset4 = 1'b1;
    k = cyc;
    for (int i = 1; i <= 13; i++) begin
      @(posedge clk); #1;
      exp = 64'((cyc - k) / 4);
      total++; if (mt4 !== exp) $display("FAIL div4_step i=%0d got %h exp %h", i, mt4, exp); else passed++;
    end
    wr4 = 1'b1;
    a4  = A_MTL;
    d4  = 32'd100;
    @(posedge clk); #1;
    c   = cyc;
    wr4 = 1'b0;
    total++; if (resp4 !== 1'b1) $display("FAIL div4_resp got %b exp 1", resp4); else passed++;
    for (int i = 0; i < 9; i++) begin
      exp = 64'd100 + 64'((cyc - c) / 4);
      total++; if (mt4 !== exp) $display("FAIL div4_presc_reset i=%0d got %h exp %h", i, mt4, exp); else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    longint c;
    logic r0, r1;
    logic [31:0] d0, d1;
    apply_reset();
    bus(1'b0, 1'b1, A_CMPH, 32'h0, c, r0, d0, r1, d1);
    write_request = 1'b1;
    address       = A_CMPL;
    write_data    = 32'h0;
    @(posedge clk); #1;
    write_request = 1'b0;
    total++; if (response !== 1'b1) $display("FAIL midrst_pre_resp got %b exp 1", response); else passed++;
    #2;
    reset = 1'b0;
    #1;
    total++; if (response !== 1'b0) $display("FAIL midrst_resp got %b exp 0", response); else passed++;
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset_release();
    total++; if (response !== 1'b0) $display("FAIL midrst_no_pulse got %b exp 0", response); else passed++;
    bus(1'b1, 1'b0, A_CMPL, 32'h0, c, r0, d0, r1, d1);
    total++; if (d0 !== 32'hFFFF_FFFF) $display("FAIL midrst_cmp_lo got %h exp ffffffff", d0); else passed++;
    bus(1'b1, 1'b0, A_CMPH, 32'h0, c, r0, d0, r1, d1);
    total++; if (d0 !== 32'hFFFF_FFFF) $display("FAIL midrst_cmp_hi got %h exp ffffffff", d0); else passed++;
    total++; if (irq_t !== 1'b0) $display("FAIL midrst_irq got %b exp 0", irq_t); else passed++;
  endtask

  task automatic test_random();
    longint c;
    logic r0, r1;
    logic [31:0] d0, d1, d, exp;
    logic [15:0] a;
    logic [63:0] m, mexp;
    logic        wr, iexp;
    int          sel;
    for (int n = 0; n < 60; n++) begin
      sel = int'($urandom_range(0, 5));
      case (sel)
        0: a = A_MSIP;
        1: a = A_CMPL;
        2: a = A_CMPH;
        3: a = A_MTL;
        4: a = A_MTH;
        default: a = 16'h1000 + 16'($urandom_range(0, 255) * 4);
      endcase
      wr = ($urandom_range(0, 1) == 1);
      m = mt_at(cyc);
      case (a)
        A_CMPL: d = m[31:0] + $urandom_range(0, 30);
        A_CMPH: d = m[63:32];
        A_MTL:  d = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15) : $urandom;
        A_MTH:  d = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
        default: d = $urandom;
      endcase
      bus(~wr, wr, a, d, c, r0, d0, r1, d1);
      exp = wr ? 32'd0 : reg_at(a, c - 1);
      total++; if (r0 !== 1'b1 || d0 !== exp) $display("FAIL rnd_xfer n=%0d a=%h got %b/%h exp 1/%h", n, a, r0, d0, exp); else passed++;
      total++; if (r1 !== 1'b0 || d1 !== 32'd0) $display("FAIL rnd_after n=%0d got %b/%h exp 0/0", n, r1, d1); else passed++;
      mexp = mt_at(cyc);
      total++; if (mtime_value !== mexp) $display("FAIL rnd_mtime n=%0d got %h exp %h", n, mtime_value, mexp); else passed++;
      iexp = (mt_at(cyc - 1) >= cmp_m);
      total++; if (irq_t !== iexp || irq_s !== msip_m) $display("FAIL rnd_irq n=%0d got %b%b exp %b%b", n, irq_t, irq_s, iexp, msip_m); else passed++;
    end
  endtask

  initial begin
    reset         = 1'b1;
    reset4        = 1'b1;
    read_request  = 1'b0;
    write_request = 1'b0;
    address       = 16'h0;
    write_data    = 32'h0;
    rr4           = 1'b0;
    wr4           = 1'b0;
    a4            = 16'h0;
    d4            = 32'h0;
    anc_val       = 64'd0;
    anc_e         = 0;
    cmp_m         = '1;
    msip_m        = 1'b0;
    test_reset();
    test_timer_irq();
    test_msip();
    test_wrap();
    test_simul_rw();
    test_hold();
    test_div4();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
